// File: rtl/decade_seq_pkg.sv
// decade_seq_pkg: shared encodings and next-count helpers for the decade counter sequencer.
package decade_seq_pkg;

    // Command opcodes carried on cmd_op_i
    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_SET9  = 2'b01,
        OP_COUNT = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    // Counting modes carried on cmd_mode_i; the reserved code behaves as BCD
    typedef enum logic [1:0] {
        MODE_BCD  = 2'b00,
        MODE_DIV2 = 2'b01,
        MODE_DIV5 = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE     = 3'd1,
        ST_PULSE_LO = 3'd2,
        ST_PULSE_HI = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_SAMPLE   = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Which counter clock input a pulse is aimed at
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    localparam logic [3:0] VAL_ZERO = 4'd0;
    localparam logic [3:0] VAL_NINE = 4'd9;

    // Fold the reserved mode onto BCD so the datapath only sees three modes
    function automatic mode_e norm_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b01:   r = MODE_DIV2;
            2'b10:   r = MODE_DIV5;
            default: r = MODE_BCD;
        endcase
        return r;
    endfunction

    // Div-5 section (QD..QB): 0..4 then wrap
    function automatic logic [2:0] div5_next(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // Full BCD step: QA toggles, and its 1->0 transition advances the div-5 section
    function automatic logic [3:0] bcd_next(input logic [3:0] v);
        logic [2:0] hi;
        hi = v[0] ? div5_next(v[3:1]) : v[3:1];
        return {hi, ~v[0]};
    endfunction

endpackage

// File: rtl/decade_seq_timer.sv
// decade_seq_timer: loadable down-counter with zero flag, shared by pulse and settle windows.
module decade_seq_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decade_counter_seq.sv
// decade_counter_seq: command sequencer driving a two-section ripple decade counter.
// Optional build macro DECADE_SEQ_CHECK_EN adds an expected-count model and sticky err_o.
module decade_counter_seq
    import decade_seq_pkg::*;
#(
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned SETTLE_W = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [1:0]       cmd_mode_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic [3:0]       q_i,
    output logic             cnt_a_o,
    output logic             cnt_b_o,
    output logic [1:0]       r0_o,
    output logic [1:0]       r9_o,
    output logic [3:0]       value_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned WIN_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int unsigned TMR_W   = $clog2(WIN_MAX) + 1;
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_W - 1);

    state_e           state, state_n;
    op_e              op_q, op_n;
    mode_e            mode_q, mode_n;
    chan_e            chan, chan_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             qa_prev, qa_prev_n;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             sample_en;

    logic             ready_n, cnt_a_n, cnt_b_n, done_n;
    logic [1:0]       r0_n, r9_n;

    decade_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state, window timer control and next registered output values
    always_comb begin
        state_n   = state;
        op_n      = op_q;
        mode_n    = mode_q;
        chan_n    = chan;
        rem_n     = rem;
        qa_prev_n = qa_prev;
        tmr_load  = 1'b0;
        tmr_val   = PULSE_LD;
        sample_en = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    op_n   = op_e'(cmd_op_i);
                    mode_n = norm_mode(cmd_mode_i);
                    rem_n  = cmd_cnt_i;
                    chan_n = (norm_mode(cmd_mode_i) == MODE_DIV5) ? CH_B : CH_A;
                    case (op_e'(cmd_op_i))
                        OP_CLEAR, OP_SET9: begin
                            state_n  = ST_GATE;
                            tmr_load = 1'b1;
                            tmr_val  = PULSE_LD;
                        end
                        OP_COUNT: begin
                            if (cmd_cnt_i != '0) begin
                                state_n  = ST_PULSE_LO;
                                tmr_load = 1'b1;
                                tmr_val  = PULSE_LD;
                            end else begin
                                state_n  = ST_SETTLE;
                                tmr_load = 1'b1;
                                tmr_val  = SETTLE_LD;
                            end
                        end
                        default: begin
                            state_n  = ST_SETTLE;
                            tmr_load = 1'b1;
                            tmr_val  = SETTLE_LD;
                        end
                    endcase
                end
            end
            ST_GATE, ST_PULSE_HI: begin
                if (tmr_zero) begin
                    state_n  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            ST_PULSE_LO: begin
                if (tmr_zero) begin
                    state_n  = ST_PULSE_HI;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_n = ST_SAMPLE;
                    if (op_q == OP_COUNT && rem != '0) begin
                        // In BCD a B pulse is a carry, not a counted input: resume A without decrementing
                        if (mode_q == MODE_BCD && chan == CH_B) begin
                            chan_n   = CH_A;
                            state_n  = ST_PULSE_LO;
                            tmr_load = 1'b1;
                            tmr_val  = PULSE_LD;
                        end else begin
                            rem_n = rem - 1'b1;
                            if (mode_q == MODE_BCD && qa_prev && !q_i[0]) begin
                                chan_n   = CH_B;
                                state_n  = ST_PULSE_LO;
                                tmr_load = 1'b1;
                                tmr_val  = PULSE_LD;
                            end else if (rem != CNT_W'(1)) begin
                                state_n  = ST_PULSE_LO;
                                tmr_load = 1'b1;
                                tmr_val  = PULSE_LD;
                            end
                        end
                    end
                end
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                state_n   = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // QA is captured just before each A pulse to detect its 1->0 carry afterwards
        if (state_n == ST_PULSE_LO && state != ST_PULSE_LO && chan_n == CH_A) begin
            qa_prev_n = q_i[0];
        end

        ready_n = (state_n == ST_IDLE);
        cnt_a_n = !(state_n == ST_PULSE_LO && chan_n == CH_A);
        cnt_b_n = !(state_n == ST_PULSE_LO && chan_n == CH_B);
        r0_n    = (state_n == ST_GATE && op_n == OP_CLEAR) ? 2'b11 : 2'b00;
        r9_n    = (state_n == ST_GATE && op_n == OP_SET9)  ? 2'b11 : 2'b00;
        done_n  = (state_n == ST_DONE);
    end

    // State, command context and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            op_q        <= OP_CLEAR;
            mode_q      <= MODE_BCD;
            chan        <= CH_A;
            rem         <= '0;
            qa_prev     <= 1'b0;
            cmd_ready_o <= 1'b0;
            cnt_a_o     <= 1'b1;
            cnt_b_o     <= 1'b1;
            r0_o        <= '0;
            r9_o        <= '0;
            value_o     <= '0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            mode_q      <= mode_n;
            chan        <= chan_n;
            rem         <= rem_n;
            qa_prev     <= qa_prev_n;
            cmd_ready_o <= ready_n;
            cnt_a_o     <= cnt_a_n;
            cnt_b_o     <= cnt_b_n;
            r0_o        <= r0_n;
            r9_o        <= r9_n;
            done_o      <= done_n;
            if (sample_en) begin
                value_o <= q_i;
            end
        end
    end

`ifdef DECADE_SEQ_CHECK_EN
    logic [3:0] model;
    logic       err_q;

    // Expected-count model, advanced on each falling clock edge issued; compared at SAMPLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            model <= '0;
            err_q <= 1'b0;
        end else if (state == ST_IDLE && state_n == ST_GATE) begin
            model <= (op_n == OP_CLEAR) ? VAL_ZERO : VAL_NINE;
        end else if (state_n == ST_PULSE_LO && state != ST_PULSE_LO) begin
            if (chan_n == CH_A && mode_n == MODE_BCD) begin
                model <= bcd_next(model);
            end else if (chan_n == CH_A && mode_n == MODE_DIV2) begin
                model <= {model[3:1], ~model[0]};
            end else if (chan_n == CH_B && mode_n == MODE_DIV5) begin
                model <= {div5_next(model[3:1]), model[0]};
            end
        end else if (sample_en) begin
            if (op_q == OP_READ) begin
                model <= q_i;
            end else if (q_i != model) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
